// File: rtl/seg_counter_multi.sv
// seg_counter_multi: N-digit BCD modulo counter (up/down, prescaled, loadable) with wrap pulse
// and active-low gfedcba 7-segment decoders. Define SEG_BLANK_EN for leading-zero blanking.
module seg_counter_multi #(
  parameter int DIGITS    = 2,
  parameter int MODULO    = 60,
  parameter int TICK_DIV  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic                ck,
  input  logic                rs,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*4-1:0] load_val,
  output logic [DIGITS*4-1:0] bcd,
  output logic [DIGITS*7-1:0] hex,
  output logic                carry
);

  localparam int W  = DIGITS * 4;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] res;
    int           v;
    res = {W{1'b0}};
    v   = value;
    for (int i = 0; i < DIGITS; i++) begin
      res[i*4 +: 4] = 4'(v % 32'sd10);
      v             = v / 32'sd10;
    end
    return res;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Ripple increment: a digit at 9 rolls to 0 and carries into the next digit.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] c);
    logic [W-1:0] r;
    logic         cy;
    r  = c;
    cy = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cy) begin
        if (c[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          cy          = 1'b1;
        end else begin
          r[i*4 +: 4] = c[i*4 +: 4] + 4'd1;
          cy          = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = c[i*4 +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] c);
    logic [W-1:0] r;
    logic         bw;
    r  = c;
    bw = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bw) begin
        if (c[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
          bw          = 1'b1;
        end else begin
          r[i*4 +: 4] = c[i*4 +: 4] - 4'd1;
          bw          = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = c[i*4 +: 4];
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0]  RESET_BCD = to_bcd(RESET_VAL);
  localparam logic [W-1:0]  MAX_BCD   = to_bcd(MODULO - 1);
  localparam logic [W-1:0]  ZERO_BCD  = {W{1'b0}};
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO  = PW'(0);

  logic [W-1:0]  cnt_r;
  logic [W-1:0]  cnt_nxt_s;
  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_nxt_s;
  logic          carry_r;
  logic          carry_nxt_s;
  logic          load_ok_s;

  // Load value check; with every digit valid, BCD magnitude order equals decimal order.
  always_comb begin
    load_ok_s = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      load_ok_s = load_ok_s & (load_val[i*4 +: 4] <= 4'd9);
    end
  end

  // Next-state: load beats the prescaler/step; carry only on a wrapping step.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    pre_nxt_s   = pre_r;
    carry_nxt_s = 1'b0;
    if (load) begin
      pre_nxt_s = PRE_ZERO;
      if (load_ok_s) begin
        cnt_nxt_s = load_val;
      end else begin
        cnt_nxt_s = ZERO_BCD;
      end
    end else if (en) begin
      if (pre_r == PRE_MAX) begin
        pre_nxt_s = PRE_ZERO;
        if (up) begin
          if (cnt_r == MAX_BCD) begin
            cnt_nxt_s   = ZERO_BCD;
            carry_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = bcd_inc(cnt_r);
          end
        end else begin
          if (cnt_r == ZERO_BCD) begin
            cnt_nxt_s   = MAX_BCD;
            carry_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = bcd_dec(cnt_r);
          end
        end
      end else begin
        pre_nxt_s = pre_r + PRE_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
      pre_nxt_s = pre_r;
    end
  end

  // State registers with asynchronous reset to RESET_VAL.
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      cnt_r   <= RESET_BCD;
      pre_r   <= PRE_ZERO;
      carry_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      pre_r   <= pre_nxt_s;
      carry_r <= carry_nxt_s;
    end
  end

  assign bcd   = cnt_r;
  assign carry = carry_r;

`ifdef SEG_BLANK_EN
  logic lead_s;

  // Segment decode, scanning from the top digit; zeros above the first non-zero digit blank.
  always_comb begin
    hex    = {(DIGITS*7){1'b1}};
    lead_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((i > 0) && lead_s && (cnt_r[i*4 +: 4] == 4'd0)) begin
        hex[i*7 +: 7] = 7'b1111111;
      end else begin
        hex[i*7 +: 7] = seg7(cnt_r[i*4 +: 4]);
        lead_s        = 1'b0;
      end
    end
  end
`else
  // Segment decode of every digit, leading zeros shown.
  always_comb begin
    hex = {(DIGITS*7){1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      hex[i*7 +: 7] = seg7(cnt_r[i*4 +: 4]);
    end
  end
`endif

endmodule

// File: tb/tb_seg_counter_multi.sv
// Self-checking bench for seg_counter_multi: four parameter sets share one stimulus stream and
// are compared each cycle against an integer reference model; directed steps plus random traffic.
module tb_seg_counter_multi;

  logic        ck = 1'b0;
  logic        rs, en, up, load;
  logic [11:0] lv;
  logic [7:0]  bcd0, bcd1, bcd2;
  logic [11:0] bcd3;
  logic [13:0] hex0, hex1, hex2;
  logic [20:0] hex3;
  logic        car0, car1, car2, car3;

  int n_cmp  = 0;
  int n_fail = 0;

  int p_dig[4] = '{2, 2, 2, 3};
  int p_mod[4] = '{60, 60, 60, 250};
  int p_div[4] = '{1, 4, 1, 3};
  int p_rst[4] = '{0, 0, 45, 7};
  int m_cnt[4];
  int m_pre[4];
  bit m_car[4];

  logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 ck = ~ck;

  seg_counter_multi #(.DIGITS(2), .MODULO(60), .TICK_DIV(1), .RESET_VAL(0)) u0 (
    .ck(ck), .rs(rs), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .bcd(bcd0), .hex(hex0), .carry(car0));
  seg_counter_multi #(.DIGITS(2), .MODULO(60), .TICK_DIV(4), .RESET_VAL(0)) u1 (
    .ck(ck), .rs(rs), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .bcd(bcd1), .hex(hex1), .carry(car1));
  seg_counter_multi #(.DIGITS(2), .MODULO(60), .TICK_DIV(1), .RESET_VAL(45)) u2 (
    .ck(ck), .rs(rs), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .bcd(bcd2), .hex(hex2), .carry(car2));
  seg_counter_multi #(.DIGITS(3), .MODULO(250), .TICK_DIV(3), .RESET_VAL(7)) u3 (
    .ck(ck), .rs(rs), .en(en), .up(up), .load(load), .load_val(lv),
    .bcd(bcd3), .hex(hex3), .carry(car3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_bcd(input int k);
    case (k)
      0:       return {24'd0, bcd0};
      1:       return {24'd0, bcd1};
      2:       return {24'd0, bcd2};
      default: return {20'd0, bcd3};
    endcase
  endfunction

  function automatic logic [31:0] obs_hex(input int k);
    case (k)
      0:       return {18'd0, hex0};
      1:       return {18'd0, hex1};
      2:       return {18'd0, hex2};
      default: return {11'd0, hex3};
    endcase
  endfunction

  function automatic logic obs_car(input int k);
    case (k)
      0:       return car0;
      1:       return car1;
      2:       return car2;
      default: return car3;
    endcase
  endfunction

  function automatic logic [31:0] exp_bcd(input int k);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < p_dig[k]; i++) r[i*4 +: 4] = 4'((m_cnt[k] / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] exp_hex(input int k);
    logic [31:0] r = 32'd0;
    bit blank;
    for (int i = 0; i < p_dig[k]; i++) begin
`ifdef SEG_BLANK_EN
      blank = (i > 0) && (m_cnt[k] < 10 ** i);
`else
      blank = 1'b0;
`endif
      r[i*7 +: 7] = blank ? 7'b1111111 : seg_tab[(m_cnt[k] / (10 ** i)) % 10];
    end
    return r;
  endfunction

  // Decimal value of the load word for instance k, or 0 if it is not a legal count.
  function automatic int ld_value(input int k);
    int v = 0;
    int d;
    for (int i = 0; i < p_dig[k]; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) return 0;
      v += d * (10 ** i);
    end
    return (v >= p_mod[k]) ? 0 : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = p_rst[k];
      m_pre[k] = 0;
      m_car[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      m_car[k] = 1'b0;
      if (load) begin
        m_cnt[k] = ld_value(k);
        m_pre[k] = 0;
      end else if (en) begin
        m_pre[k] = (m_pre[k] + 1) % p_div[k];
        if (m_pre[k] == 0) begin
          if (up) begin
            m_car[k] = (m_cnt[k] == p_mod[k] - 1);
            m_cnt[k] = (m_cnt[k] + 1) % p_mod[k];
          end else begin
            m_car[k] = (m_cnt[k] == 0);
            m_cnt[k] = (m_cnt[k] + p_mod[k] - 1) % p_mod[k];
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bcd%0d", k), obs_bcd(k), exp_bcd(k));
      chk($sformatf("hex%0d", k), obs_hex(k), exp_hex(k));
      chk($sformatf("carry%0d", k), {31'd0, obs_car(k)}, {31'd0, m_car[k]});
    end
  endtask

  task automatic cycle();
    @(posedge ck);
    model_edge();
    #1;
    check_all();
  endtask

  // Pulse rs between edges; outputs must switch without any clock edge.
  task automatic async_reset();
    #2;
    rs = 1'b1;
    model_reset();
    #1;
    chk("async_bcd2", {24'd0, bcd2}, 32'h45);
    chk("async_car2", {31'd0, car2}, 32'd0);
    check_all();
    #1;
    rs = 1'b0;
  endtask

  initial begin
    rs = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 12'h000;
    @(posedge ck);
    #1;
    model_reset();
    check_all();
    chk("reset_bcd2", {24'd0, bcd2}, 32'h45);
    chk("reset_bcd3", {20'd0, bcd3}, 32'h007);
    rs = 1'b0;

    // Count up through the wrap.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 59; i++) cycle();
    chk("up_59", {24'd0, bcd0}, 32'h59);
    chk("up_59_carry", {31'd0, car0}, 32'd0);
    cycle();
    chk("wrap_bcd", {24'd0, bcd0}, 32'h00);
    chk("wrap_carry", {31'd0, car0}, 32'd1);
    chk("wrap_hex", {25'd0, hex0[6:0]}, {25'd0, 7'b1000000});
    cycle();
    chk("after_wrap_carry", {31'd0, car0}, 32'd0);

    // Count down with borrow, and the down wrap.
    lv = 12'h010; load = 1'b1; cycle();
    load = 1'b0; up = 1'b0; cycle();
    chk("down_09", {24'd0, bcd0}, 32'h09);
    cycle();
    chk("down_08", {24'd0, bcd0}, 32'h08);
    lv = 12'h000; load = 1'b1; cycle();
    load = 1'b0; cycle();
    chk("down_wrap_bcd", {24'd0, bcd0}, 32'h59);
    chk("down_wrap_carry", {31'd0, car0}, 32'd1);

    // Load over a coincident wrapping step, then out-of-range and non-BCD loads.
    up = 1'b1; lv = 12'h023; load = 1'b1; cycle();
    chk("load_23", {24'd0, bcd0}, 32'h23);
    chk("load_no_carry", {31'd0, car0}, 32'd0);
    lv = 12'h075; cycle();
    chk("load_75", {24'd0, bcd0}, 32'h00);
    chk("load_75_3dig", {20'd0, bcd3}, 32'h075);
    lv = 12'h01A; cycle();
    chk("load_1A", {24'd0, bcd0}, 32'h00);

    // Prescaler: a 3-clock en gap inside a period delays the step by 3 clocks.
    lv = 12'h000; cycle();
    load = 1'b0; cycle(); cycle();
    en = 1'b0; cycle(); cycle(); cycle();
    en = 1'b1; cycle();
    chk("pre_hold", {24'd0, bcd1}, 32'h00);
    cycle();
    chk("pre_step1", {24'd0, bcd1}, 32'h01);
    for (int i = 0; i < 4; i++) cycle();
    chk("pre_step2", {24'd0, bcd1}, 32'h02);

    // Asynchronous reset from count 17.
    lv = 12'h017; load = 1'b1; cycle();
    load = 1'b0; en = 1'b0; cycle();
    chk("pre_rst_17", {24'd0, bcd2}, 32'h17);
    async_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Display of 05 and 00.
    en = 1'b0; lv = 12'h005; load = 1'b1; cycle();
`ifdef SEG_BLANK_EN
    chk("hex_05_hi", {25'd0, hex0[13:7]}, {25'd0, 7'b1111111});
`else
    chk("hex_05_hi", {25'd0, hex0[13:7]}, {25'd0, 7'b1000000});
`endif
    chk("hex_05_lo", {25'd0, hex0[6:0]}, {25'd0, 7'b0010010});
    lv = 12'h000; cycle();
    chk("hex_00_lo", {25'd0, hex0[6:0]}, {25'd0, 7'b1000000});
    load = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) != 0;
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) != 0) begin
        lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        lv = 12'($urandom);
      end
      if ($urandom_range(0, 99) == 0) async_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
